ahb_mem_slave: RTL and testbench

//  AHB-Lite memory slave on the bus side of the AHB master; consumes haddr/hwrite/hsize/htrans/hwdata.

---
 rtl/ahb_mem_slave.sv | 165 ++++++++++++++++
 tb/tb_ahb_mem_slave.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ahb_mem_slave.sv
// AHB-Lite word-organised RAM slave with programmable wait states and byte/halfword write lanes.
// Optional ERROR response for bad address/size/alignment is built when AHB_SLV_ERR_EN is defined.
module ahb_mem_slave #(
    parameter int          ADDR_W      = 8,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [3:0]  hprot,
    input  logic [1:0]  htrans,
    input  logic        hmastlock,
    input  logic        hready,
    input  logic [31:0] hwdata,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata
);

    localparam int         DEPTH   = 2 ** ADDR_W;
    localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LAST, S_ERR1, S_ERR2} state_e;

    state_e              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                write_q, write_d;
    logic [3:0]          lanes_q, lanes_d;
    logic                hreadyout_q, hreadyout_d;
    logic [31:0]         hrdata_q, hrdata_d;
    logic [31:0]         ram_q [DEPTH];

    logic                accept, err_in, commit, fetch;
    logic [3:0]          lanes_in;
    logic [ADDR_W-1:0]   addr_in, fetch_addr;
    logic [31:0]         wr_word;

    logic unused_ok;
    assign unused_ok = ^{hburst, hprot, hmastlock, htrans[0], haddr[31:ADDR_W+2], BASE_ADDR};

    assign addr_in = haddr[ADDR_W+1:2];
    assign accept  = hsel & hready & htrans[1] &
                     (state_q == S_IDLE || state_q == S_LAST || state_q == S_ERR2);
    assign commit  = (state_q == S_LAST) & write_q;

    // Lane decode ignores the low address bits that would misalign a halfword/word.
    always_comb begin
        case (hsize)
            3'b000:  lanes_in = 4'b0001 << haddr[1:0];
            3'b001:  lanes_in = haddr[1] ? 4'b1100 : 4'b0011;
            default: lanes_in = 4'b1111;
        endcase
    end

`ifdef AHB_SLV_ERR_EN
    assign err_in = (haddr[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2]) |
                    (hsize > 3'b010) |
                    ((hsize == 3'b001) & haddr[0]) |
                    ((hsize == 3'b010) & (|haddr[1:0]));
`else
    assign err_in = 1'b0;
`endif

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            wr_word[8*i +: 8] = lanes_q[i] ? hwdata[8*i +: 8] : ram_q[addr_q][8*i +: 8];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        write_d    = write_q;
        lanes_d    = lanes_q;
        fetch      = 1'b0;
        fetch_addr = addr_q;
        case (state_q)
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_LAST;
                    fetch   = ~write_q;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
`ifdef AHB_SLV_ERR_EN
            S_ERR1:  state_d = S_ERR2;
`endif
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            addr_d  = addr_in;
            write_d = hwrite;
            lanes_d = lanes_in;
            if (err_in) begin
                state_d = S_ERR1;
            end else if (WAIT_STATES > 0) begin
                state_d = S_WAIT;
                cnt_d   = WS_LOAD;
            end else begin
                // Zero-wait: the read fetches on the same edge the previous write commits.
                state_d    = S_LAST;
                fetch      = ~hwrite;
                fetch_addr = addr_in;
            end
        end
    end

    always_comb begin
        hrdata_d = hrdata_q;
        if (fetch) begin
            hrdata_d = (commit && fetch_addr == addr_q) ? wr_word : ram_q[fetch_addr];
        end
        hreadyout_d = !(state_d == S_WAIT || state_d == S_ERR1);
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            lanes_q     <= 4'b0;
            hreadyout_q <= 1'b1;
            hrdata_q    <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            lanes_q     <= lanes_d;
            hreadyout_q <= hreadyout_d;
            hrdata_q    <= hrdata_d;
        end
    end

    always_ff @(posedge hclk) begin
        if (commit) begin
            ram_q[addr_q] <= wr_word;
        end
    end

`ifdef AHB_SLV_ERR_EN
    logic hresp_q, hresp_d;
    assign hresp_d = (state_d == S_ERR1) || (state_d == S_ERR2);
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) hresp_q <= 1'b0;
        else          hresp_q <= hresp_d;
    end
    assign hresp = hresp_q;
`else
    assign hresp = 1'b0;
`endif

    assign hreadyout = hreadyout_q;
    assign hrdata    = hrdata_q;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Directed bench: instance A has one wait state, instance B has none; each is its own bus master's only slave.
module tb_ahb_mem_slave;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        hsel_a, hsel_b;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic        hreadyout_a, hresp_a, hreadyout_b, hresp_b;
    logic [31:0] hrdata_a, hrdata_b;
    logic [31:0] rd;
    int          waits;
    int          checks = 0;
    int          errors = 0;

    always #5 hclk = ~hclk;

    ahb_mem_slave #(.ADDR_W(8), .WAIT_STATES(1), .BASE_ADDR(32'h0)) u_a (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel_a), .haddr(haddr), .hwrite(hwrite),
        .hsize(hsize), .hburst(3'b000), .hprot(4'b0011), .htrans(htrans), .hmastlock(1'b0),
        .hready(hreadyout_a), .hwdata(hwdata),
        .hreadyout(hreadyout_a), .hresp(hresp_a), .hrdata(hrdata_a));

    ahb_mem_slave #(.ADDR_W(8), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_b (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel_b), .haddr(haddr), .hwrite(hwrite),
        .hsize(hsize), .hburst(3'b000), .hprot(4'b0011), .htrans(htrans), .hmastlock(1'b0),
        .hready(hreadyout_b), .hwdata(hwdata),
        .hreadyout(hreadyout_b), .hresp(hresp_b), .hrdata(hrdata_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    // Single non-pipelined transfer; starts and ends 1ns after an edge with the target idle.
    task automatic xfer(input bit use_b, input logic [31:0] addr, input bit wr,
                        input logic [2:0] size, input logic [31:0] wdata,
                        output logic [31:0] rdata, output int nwait);
        hsel_a = !use_b; hsel_b = use_b;
        haddr = addr; hwrite = wr; hsize = size; htrans = 2'b10;
        step();
        hsel_a = 1'b0; hsel_b = 1'b0; htrans = 2'b00; hwdata = wdata;
        nwait = 0;
        while (!(use_b ? hreadyout_b : hreadyout_a) && nwait < 20) begin
            step();
            nwait++;
        end
        rdata = use_b ? hrdata_b : hrdata_a;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        hresetn = 1'b0; hsel_a = 1'b0; hsel_b = 1'b0; haddr = 32'h0; hwrite = 1'b0;
        hsize = 3'b010; htrans = 2'b00; hwdata = 32'h0;
        #12;
        chk("rst_rdy_a", 32'(hreadyout_a), 32'h1);
        chk("rst_resp_a", 32'(hresp_a), 32'h0);
        chk("rst_rdata_a", hrdata_a, 32'h0);
        chk("rst_rdy_b", 32'(hreadyout_b), 32'h1);
        chk("rst_resp_b", 32'(hresp_b), 32'h0);
        chk("rst_rdata_b", hrdata_b, 32'h0);
        @(negedge hclk) hresetn = 1'b1;
        step();

        // one wait state per data phase
        xfer(1'b0, 32'h10, 1'b1, 3'b010, 32'hDEADBEEF, rd, waits);
        chk("ws1_wr_waits", 32'(waits), 32'd1);
        xfer(1'b0, 32'h10, 1'b0, 3'b010, 32'h0, rd, waits);
        chk("ws1_rd_waits", 32'(waits), 32'd1);
        chk("ws1_rd_data", rd, 32'hDEADBEEF);
        chk("ws1_resp", 32'(hresp_a), 32'h0);

        // byte and halfword lanes
        xfer(1'b0, 32'h20, 1'b1, 3'b010, 32'h11223344, rd, waits);
        xfer(1'b0, 32'h21, 1'b1, 3'b000, 32'h0000AA00, rd, waits);
        xfer(1'b0, 32'h22, 1'b1, 3'b001, 32'hBBCC0000, rd, waits);
        xfer(1'b0, 32'h20, 1'b0, 3'b010, 32'h0, rd, waits);
        chk("lanes_merge", rd, 32'hBBCCAA44);
        xfer(1'b0, 32'h23, 1'b1, 3'b000, 32'h77000000, rd, waits);
        xfer(1'b0, 32'h20, 1'b1, 3'b001, 32'h00001234, rd, waits);
        xfer(1'b0, 32'h20, 1'b0, 3'b010, 32'h0, rd, waits);
        chk("lanes_b3_h0", rd, 32'h77CC1234);
        xfer(1'b0, 32'h24, 1'b1, 3'b010, 32'h99999999, rd, waits);
        chk("rdata_hold", hrdata_a, 32'h77CC1234);

        // zero-wait back-to-back write then read of the same word
        hsel_b = 1'b1; haddr = 32'h4; hwrite = 1'b1; hsize = 3'b010; htrans = 2'b10;
        step();
        chk("b2b_w_rdy", 32'(hreadyout_b), 32'h1);
        hwdata = 32'h5; haddr = 32'h4; hwrite = 1'b0; htrans = 2'b10;
        step();
        chk("b2b_r_rdy", 32'(hreadyout_b), 32'h1);
        chk("b2b_fwd", hrdata_b, 32'h5);
        hsel_b = 1'b0; htrans = 2'b00;
        step();
        chk("b2b_idle_rdy", 32'(hreadyout_b), 32'h1);
        chk("b2b_hold", hrdata_b, 32'h5);

        xfer(1'b1, 32'h8, 1'b1, 3'b010, 32'hA0B0C0D0, rd, waits);
        chk("ws0_waits", 32'(waits), 32'd0);
        hsel_b = 1'b1; haddr = 32'h9; hwrite = 1'b1; hsize = 3'b000; htrans = 2'b10;
        step();
        hwdata = 32'h0000EE00; haddr = 32'h8; hwrite = 1'b0; hsize = 3'b010; htrans = 2'b10;
        step();
        chk("b2b_fwd_byte", hrdata_b, 32'hA0B0EED0);
        hsel_b = 1'b0; htrans = 2'b00;
        step();
        xfer(1'b1, 32'h8, 1'b0, 3'b010, 32'h0, rd, waits);
        chk("b2b_byte_ram", rd, 32'hA0B0EED0);

`ifdef AHB_SLV_ERR_EN
        hsel_a = 1'b1; haddr = 32'h400; hwrite = 1'b0; hsize = 3'b010; htrans = 2'b10;
        step();
        hsel_a = 1'b0; htrans = 2'b00;
        chk("err1_rdy", 32'(hreadyout_a), 32'h0);
        chk("err1_resp", 32'(hresp_a), 32'h1);
        step();
        chk("err2_rdy", 32'(hreadyout_a), 32'h1);
        chk("err2_resp", 32'(hresp_a), 32'h1);
        chk("err_rdata", hrdata_a, 32'h77CC1234);
        step();
        chk("err_done_resp", 32'(hresp_a), 32'h0);
        xfer(1'b0, 32'h412, 1'b1, 3'b001, 32'h55550000, rd, waits);
        xfer(1'b0, 32'h10, 1'b0, 3'b010, 32'h0, rd, waits);
        chk("err_no_wr", rd, 32'hDEADBEEF);
`else
        xfer(1'b0, 32'h430, 1'b1, 3'b010, 32'hCAFEF00D, rd, waits);
        xfer(1'b0, 32'h30, 1'b0, 3'b010, 32'h0, rd, waits);
        chk("wrap_rd", rd, 32'hCAFEF00D);
        chk("wrap_resp", 32'(hresp_a), 32'h0);
        xfer(1'b0, 32'h33, 1'b1, 3'b011, 32'h01020304, rd, waits);
        xfer(1'b0, 32'h30, 1'b0, 3'b010, 32'h0, rd, waits);
        chk("align_size3", rd, 32'h01020304);
`endif

        // reset while a write sits in its wait state
        hsel_a = 1'b1; haddr = 32'h10; hwrite = 1'b1; hsize = 3'b010; htrans = 2'b10;
        step();
        chk("rst_mid_wait", 32'(hreadyout_a), 32'h0);
        hsel_a = 1'b0; htrans = 2'b00; hwdata = 32'h12345678;
        #2 hresetn = 1'b0;
        #1;
        chk("rst_mid_rdy", 32'(hreadyout_a), 32'h1);
        chk("rst_mid_rdata", hrdata_a, 32'h0);
        chk("rst_mid_resp", 32'(hresp_a), 32'h0);
        @(negedge hclk) hresetn = 1'b1;
        step();
        xfer(1'b0, 32'h10, 1'b0, 3'b010, 32'h0, rd, waits);
        chk("rst_mid_keep", rd, 32'hDEADBEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
